// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory port
//               arbiter. It holds the FSM state encoding, the requester id,
//               the instruction word width and the fairness streak width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // The transaction FSM uses fixed 2-bit codes.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } requester_t;

    localparam int IF_W     = 32;  // instruction word width
    localparam int STREAK_W = 4;   // data-grant streak counter width

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_select
// Description : Chooses the winner between fetch and data requests and
//               tracks the streak of contended data grants. Data normally
//               wins. Fetch wins when it is the only requester, or when data
//               has already won MAX_DATA_STREAK contended grants in a row.
// Ports       : clk, rst        - clock, async active-high reset
//               if_req, d_req   - raw requests from the two ports
//               grant_fire      - a grant is taken at the next edge
//               o_sel_if/o_sel_d- one-hot winner (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_fire,
    output logic o_sel_if,
    output logic o_sel_d
);

    localparam logic [STREAK_W-1:0] c_MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_if;

    always_comb begin
        w_force_if = if_req && (r_streak == c_MAX_STREAK);
        o_sel_d    = d_req && !w_force_if;
        o_sel_if   = if_req && !o_sel_d;
    end

    // Only a data win that actually beat a waiting fetch extends the streak.
    // An uncontended data grant and any fetch grant both start a new streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (grant_fire) begin
            if (o_sel_d && if_req) begin
                if (r_streak != c_MAX_STREAK) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported unified memory between instruction
//               fetch and load/store. It keeps one transaction in flight:
//               grant (IDLE) -> request held until mem_ready (ISSUE) ->
//               wait for mem_rvalid (WAIT) -> one-cycle response (RESP).
//               A watchdog aborts a stuck transaction with rsp_err.
// Ports       : if_*   - fetch port (req/addr in, gnt/rvalid/rdata out)
//               d_*    - data port (req/we/addr/wdata in, gnt/rvalid/rdata)
//               mem_*  - memory handshake
//               rsp_err, busy, err_timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [IF_W-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_timeout
);

    localparam int c_TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_TCNT_W-1:0] c_TMO_LAST =
        c_TCNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit c_TMO_EN = (TIMEOUT_CYCLES != 0);

    state_t              r_state;
    requester_t          r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_err_timeout;
    logic [c_TCNT_W-1:0] r_tcnt;

    logic w_sel_if;
    logic w_sel_d;
    logic w_idle;
    logic w_fire;
    logic w_tmo;
    logic w_resp;

    // Grants are combinational. Gating them with rst keeps them at 0 for the
    // whole reset pulse, including the part between clock edges.
    assign w_idle = (r_state == IDLE) && !rst;
    assign w_fire = w_idle && (if_req || d_req);

    // The counter holds the number of ISSUE/WAIT cycles already completed,
    // so it equals TIMEOUT_CYCLES-1 in the last allowed cycle.
    assign w_tmo  = c_TMO_EN && (r_tcnt == c_TMO_LAST);

    mem_arb_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_select (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .d_req      (d_req),
        .grant_fire (w_fire),
        .o_sel_if   (w_sel_if),
        .o_sel_d    (w_sel_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= REQ_IF;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_state <= ISSUE;
                        r_tcnt  <= '0;
                        r_err   <= 1'b0;
                        if (w_sel_d) begin
                            r_owner <= REQ_D;
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_owner <= REQ_IF;
                            r_addr  <= if_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                        end
                    end
                end
                // A memory event in the same cycle as expiry takes priority
                // over the timeout.
                ISSUE: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (mem_ready) begin
                        r_state <= WAIT;
                    end else if (w_tmo) begin
                        r_state       <= RESP;
                        r_rdata       <= '0;
                        r_err         <= 1'b1;
                        r_err_timeout <= 1'b1;
                    end
                end
                WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (mem_rvalid) begin
                        r_state <= RESP;
                        r_rdata <= mem_rdata;
                    end else if (w_tmo) begin
                        r_state       <= RESP;
                        r_rdata       <= '0;
                        r_err         <= 1'b1;
                        r_err_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_resp      = (r_state == RESP);

    assign if_gnt      = w_idle && w_sel_if;
    assign d_gnt       = w_idle && w_sel_d;

    assign mem_req     = (r_state == ISSUE);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

    assign if_rvalid   = w_resp && (r_owner == REQ_IF);
    assign d_rvalid    = w_resp && (r_owner == REQ_D);
    assign rsp_err     = w_resp && r_err;

    // The fetch word is the half of the 64-bit line selected by address bit 2.
    assign if_rdata    = !if_rvalid ? '0 :
                         (r_addr[2] ? r_rdata[2*IF_W-1:IF_W] : r_rdata[IF_W-1:0]);
    assign d_rdata     = (d_rvalid && !r_we) ? r_rdata : '0;

    assign busy        = (r_state != IDLE);
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Stimulus pushes the
//               expected grants, memory operations and responses into
//               queues. A monitor pops and compares them whenever the DUT
//               shows a grant, a memory handshake or a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        err_timeout;

    mem_port_arbiter #(
        .ADDR_W          (64),
        .DATA_W          (64),
        .MAX_DATA_STREAK (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .rsp_err     (rsp_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_op_t;

    typedef struct packed {
        logic        is_if;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    bit      exp_gnt_q[$];   // 1 = fetch expected to win
    mem_op_t exp_mem_q[$];
    rsp_t    exp_rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model knobs
    int          m_stall  = 0;
    bit          m_drop   = 1'b0;
    bit          m_stray  = 1'b0;
    logic [63:0] m_rdata  = 64'h0;

    function automatic mem_op_t mk_mem(input logic we, input logic [63:0] a, input logic [63:0] w);
        mem_op_t m;
        m.we = we; m.addr = a; m.wdata = w;
        return m;
    endfunction

    function automatic rsp_t mk_rsp(input logic is_if, input logic [63:0] d, input logic e);
        rsp_t r;
        r.is_if = is_if; r.data = d; r.err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: inputs change 1 time unit after the rising edge.
    initial begin
        int  stall_cnt;
        bit  pend_rsp;
        stall_cnt  = 0;
        pend_rsp   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 64'h0;
            if (m_stray) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
                m_stray    = 1'b0;
            end else if (pend_rsp) begin
                mem_rvalid = 1'b1;
                mem_rdata  = m_rdata;
                pend_rsp   = 1'b0;
            end else if (mem_req && !rst) begin
                if (stall_cnt < m_stall) begin
                    stall_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    stall_cnt = 0;
                    pend_rsp  = !m_drop;
                end
            end
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        bit      eg;
        mem_op_t em;
        rsp_t    er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_gnt || d_gnt) begin
                    if (exp_gnt_q.size() == 0) begin
                        chk("gnt_unexpected", 192'({if_gnt, d_gnt}), 192'(2'b00));
                    end else begin
                        eg = exp_gnt_q.pop_front();
                        chk("gnt_order", 192'({if_gnt, d_gnt}), 192'(eg ? 2'b10 : 2'b01));
                    end
                end
                if (mem_req && mem_ready) begin
                    if (exp_mem_q.size() == 0) begin
                        chk("mem_unexpected", 192'(mem_req), 192'(1'b0));
                    end else begin
                        em = exp_mem_q.pop_front();
                        chk("mem_op", 192'({mem_we, mem_addr, mem_wdata}), 192'(em));
                    end
                end
                if (if_rvalid || d_rvalid) begin
                    if (exp_rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 192'({if_rvalid, d_rvalid}), 192'(2'b00));
                    end else begin
                        er = exp_rsp_q.pop_front();
                        chk("rsp", 192'({if_rvalid, d_rvalid, rsp_err, if_rdata, d_rdata}),
                            er.is_if ? 192'({1'b1, 1'b0, er.err, er.data[31:0], 64'h0})
                                     : 192'({1'b0, 1'b1, er.err, 32'h0, er.data}));
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input bit is_if);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_if ? if_gnt : d_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_wait_expired", 192'(1'b0), 192'(1'b1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_wait_expired", 192'(1'b0), 192'(1'b1));
    endtask

    // One isolated transaction; exp_lat counts cycles from grant to response.
    task automatic do_req(input bit is_if, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_data,
                          input bit exp_err, input int exp_lat);
        int lat;
        bit got;
        exp_gnt_q.push_back(is_if);
        exp_mem_q.push_back(is_if ? mk_mem(1'b0, addr, 64'h0) : mk_mem(we, addr, wdata));
        exp_rsp_q.push_back(mk_rsp(is_if, exp_data, exp_err));
        @(posedge clk);
        #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        wait_gnt(is_if);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            lat++;
            if (if_rvalid || d_rvalid) begin
                got = 1'b1;
                break;
            end
        end
        chk("latency", 192'(got ? lat : 0), 192'(exp_lat));
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ngnt;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 64'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            192'({busy, if_gnt, d_gnt, if_rvalid, d_rvalid, rsp_err, mem_req, mem_we,
                  err_timeout, if_rdata, d_rdata, mem_addr, mem_wdata}), 192'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch from the upper word of a line
        m_rdata = 64'hAAAA_BBBB_1111_2222;
        do_req(1'b1, 1'b0, 64'h104, 64'h0, 64'hAAAA_BBBB, 1'b0, 3);

        // Store: response carries no data even though memory returns some
        m_rdata = 64'h5555_5555_5555_5555;
        do_req(1'b0, 1'b1, 64'h40, 64'hDEAD, 64'h0, 1'b0, 3);

        // Contention: D,D,D,D,IF,D,D,D,D,IF
        m_rdata = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 10; k++) begin
            bit f;
            f = (k == 4) || (k == 9);
            exp_gnt_q.push_back(f);
            exp_mem_q.push_back(f ? mk_mem(1'b0, 64'h8, 64'h0) : mk_mem(1'b0, 64'h300, 64'h77));
            exp_rsp_q.push_back(f ? mk_rsp(1'b1, 64'h89AB_CDEF, 1'b0)
                                  : mk_rsp(1'b0, 64'h0123_4567_89AB_CDEF, 1'b0));
        end
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 64'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; d_wdata = 64'h77;
        ngnt = 0;
        for (int i = 0; i < 200 && ngnt < 10; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) ngnt++;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("contention_grants", 192'(ngnt), 192'(10));
        wait_idle();

        // Memory stall with a fetch arriving while busy
        m_stall = 5;
        m_rdata = 64'hCAFE_F00D_1234_5678;
        exp_gnt_q.push_back(1'b0);
        exp_mem_q.push_back(mk_mem(1'b1, 64'h80, 64'h1234));
        exp_rsp_q.push_back(mk_rsp(1'b0, 64'h0, 1'b0));
        exp_gnt_q.push_back(1'b1);
        exp_mem_q.push_back(mk_mem(1'b0, 64'h24, 64'h0));
        exp_rsp_q.push_back(mk_rsp(1'b1, 64'hCAFE_F00D, 1'b0));
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h1234;
        wait_gnt(1'b0);
        @(posedge clk);
        #1;
        d_req = 1'b0; d_we = 1'b0;
        if_req = 1'b1; if_addr = 64'h24;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold",
                192'({mem_req, mem_ready, mem_we, busy, if_gnt, mem_addr, mem_wdata}),
                192'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h80, 64'h1234}));
        end
        m_stall = 0;
        wait_gnt(1'b1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        wait_idle();

        // Timeout: memory accepts but never completes
        m_drop  = 1'b1;
        m_rdata = 64'h9999_9999_9999_9999;
        do_req(1'b0, 1'b0, 64'h200, 64'h0, 64'h0, 1'b1, 9);
        m_drop = 1'b0;
        chk("err_timeout_set", 192'(err_timeout), 192'(1'b1));
        m_stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_rvalid_ignored", 192'({busy, err_timeout, if_rvalid, d_rvalid}),
            192'(4'b0100));

        // Asynchronous reset while waiting for memory
        m_drop = 1'b1;
        exp_gnt_q.push_back(1'b0);
        exp_mem_q.push_back(mk_mem(1'b0, 64'h400, 64'h0));
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400; d_wdata = 64'h0;
        wait_gnt(1'b0);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_wait", 192'({busy, mem_req}), 192'(2'b10));
        #2;
        if_req = 1'b1; if_addr = 64'h10;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            192'({busy, if_gnt, d_gnt, if_rvalid, d_rvalid, rsp_err, mem_req, mem_we,
                  err_timeout, mem_addr}), 192'(0));
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_drop = 1'b0;
        m_stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 192'({busy, err_timeout, if_rvalid, d_rvalid}), 192'(0));

        // Normal fetch after reset, lower word
        m_rdata = 64'h1111_2222_3333_4444;
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 64'h3333_4444, 1'b0, 3);

        repeat (2) @(negedge clk);
        chk("queues_drained",
            192'({exp_gnt_q.size(), exp_mem_q.size(), exp_rsp_q.size()}), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 64-bit unified memory between the instruction-fetch path and the load/store data path of the processor, for the multi-cycle/pipelined core variant.
- Accepts fetch and data requests, grants one at a time and sequences the memory handshake.
- Returns the response to the winning requester.
- Provides anti-starvation for fetch and a bounded-latency timeout.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, memory/data-port data width.
- MAX_DATA_STREAK, 4, consecutive contended data grants before fetch is forced to win (range 1-15).
- TIMEOUT_CYCLES, 64, cycles allowed in ISSUE+WAIT before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  32  instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle data response strobe (loads and stores)
- d_rdata  out  DATA_W  load data (0 for stores)
- rsp_err  out  1  qualifies the current if_rvalid/d_rvalid: transaction timed out
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory completion (read data or write ack)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset:
  - Async rst forces state IDLE.
  - All outputs 0; streak, timeout counter and captured txn registers 0.
  - Valid mid-transaction; a late mem_rvalid after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP. One outstanding transaction only.
- IDLE:
  - Winner selection is combinational.
  - If d_req and !(if_req && streak==MAX_DATA_STREAK), data wins; else if if_req, fetch wins.
  - Winner's gnt=1 the same cycle.
  - At the edge, capture requester id, address, we (fetch: we=0), wdata; go to ISSUE.
  - No request: stay IDLE, gnt=0.
- Streak counter (4 bit):
  - Data grant while if_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - Fetch grant, or data grant with if_req=0: streak=0.
- ISSUE:
  - mem_req=1 with registered mem_we/mem_addr/mem_wdata, stable until mem_ready.
  - mem_ready=1: go to WAIT.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: capture mem_rdata, go to RESP.
  - mem_rvalid outside WAIT is ignored.
- RESP (exactly one cycle, then IDLE):
  - Owner's rvalid=1.
  - d_rdata = captured data for loads, 0 for stores.
  - if_rdata = captured[31:0] if addr[2]==0, else captured[63:32].
  - Non-owner rvalid=0.
- Latency: grant in cycle N, earliest response at N+3. Next grant possible at N+4.
- Timeout:
  - Counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES (nonzero): drop mem_req, go to RESP with rdata=0 and rsp_err=1, set err_timeout (cleared only by rst).
  - A timeout and mem_rvalid/mem_ready in the same cycle: the memory event wins and no error is raised.
- Request changes while not granted are allowed. Deassertion before gnt is a legal withdrawal.
- Data outputs are 0 whenever the corresponding rvalid is 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester enum {REQ_IF, REQ_D}
  - constant IF_W=32
  - streak counter width
- Sub-module mem_arb_select: combinational winner selection plus the streak counter register, with inputs if_req, d_req, grant_fire. Keeps the fairness logic independently testable.
- FSM, capture registers and timeout stay in the top module.

Test Plan:
- Fetch only: if_req, if_addr=0x104, memory ready=1 and rvalid next cycle with rdata=0xAAAA_BBBB_1111_2222 -> if_gnt cycle 0, mem_req cycle 1, if_rvalid cycle 3 with if_rdata=0xAAAA_BBBB.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEAD -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEAD. On ack, d_rvalid=1 with d_rdata=0 and rsp_err=0.
- Contention: if_req and d_req held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF. Streak resets after each IF grant.
- Memory stall: mem_ready low for 5 cycles -> mem_req, mem_addr and mem_wdata stay stable. No new gnt while busy=1.
- Timeout: TIMEOUT_CYCLES=8, mem_rvalid never asserted, load pending -> at the 8th ISSUE/WAIT cycle go to RESP. d_rvalid=1, rsp_err=1, d_rdata=0, err_timeout stays 1; a later stray mem_rvalid is ignored.
- Async reset asserted in WAIT between clock edges -> outputs 0 immediately. After release, IDLE with streak=0 and the next fetch is served normally.
